// File: rtl/pe_sched_pkg.sv
// pe_sched_pkg: shared constants and FSM state type for the PE scheduler.
// Holds slot geometry, operand widths, watchdog limit and the state enum.
package pe_sched_pkg;

   localparam int SLOTS   = 3;
   localparam int ADDR_W  = 7;
   localparam int COORD_N = 3;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 15;

   // Packed 3-coordinate address of one beat.
   localparam int PADDR_W = ADDR_W * COORD_N;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_DONE    = 3'd4
   } pe_state_e;

endpackage

// File: rtl/pe_slot_buf.sv
// pe_slot_buf: gathers accepted beats into three operand slots and pads
// an early-closed triple with zero-weight copies of the last address.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_clear               clear slot count (entry to COLLECT)
//   i_accept, i_last      beat transfer and its last flag
//   i_addr, i_w, i_ia     beat payload
//   o_close               this accepted beat closes the triple
//   o_addr, o_w, o_ia     flattened slot operands, slot 0 in the LSBs
module pe_slot_buf
   import pe_sched_pkg::*;
(
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_clear,
   input  logic                       i_accept,
   input  logic                       i_last,
   input  logic [PADDR_W-1:0]         i_addr,
   input  logic [DATA_W-1:0]          i_w,
   input  logic [DATA_W-1:0]          i_ia,
   output logic                       o_close,
   output logic [SLOTS*PADDR_W-1:0]   o_addr,
   output logic [SLOTS*DATA_W-1:0]    o_w,
   output logic [SLOTS*DATA_W-1:0]    o_ia
);

   logic [1:0]         r_cnt;
   logic [PADDR_W-1:0] r_addr [SLOTS];
   logic [DATA_W-1:0]  r_w    [SLOTS];
   logic [DATA_W-1:0]  r_ia   [SLOTS];

   assign o_close = i_accept &
                    (i_last | (r_cnt == 2'(SLOTS-1)));

   // The closing beat also writes the pad slots in the same edge, so the
   // triple is complete by the time the reducer sees the start pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= 2'd0;
         for (int k = 0; k < SLOTS; k++) begin
            r_addr[k] <= '0;
            r_w[k]    <= '0;
            r_ia[k]   <= '0;
         end
      end else if (i_clear) begin
         r_cnt <= 2'd0;
      end else if (i_accept) begin
         r_cnt <= o_close ? 2'd0 : r_cnt + 2'd1;
         for (int k = 0; k < SLOTS; k++) begin
            if (2'(k) == r_cnt) begin
               r_addr[k] <= i_addr;
               r_w[k]    <= i_w;
               r_ia[k]   <= i_ia;
            end else if (i_last && (2'(k) > r_cnt)) begin
               r_addr[k] <= i_addr;
               r_w[k]    <= '0;
               r_ia[k]   <= '0;
            end
         end
      end
   end

   for (genvar g = 0; g < SLOTS; g++) begin : g_flat
      assign o_addr[g*PADDR_W +: PADDR_W] = r_addr[g];
      assign o_w[g*DATA_W +: DATA_W]      = r_w[g];
      assign o_ia[g*DATA_W +: DATA_W]     = r_ia[g];
   end

endmodule

// File: rtl/pe_scheduler.sv
// pe_scheduler: collects stream beats into triples and issues them to a
// reducer, one triple at a time, tracking the issued-triple count.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_job_start                    start pulse, honoured in IDLE
//   i_valid/o_ready, i_addr, i_w,
//   i_ia, i_last                   input beat stream
//   o_pe_start, o_pe_addr,
//   o_pe_w, o_pe_ia, i_pe_finish   reducer issue/completion
//   o_busy, o_done, o_error,
//   o_triple_cnt                   job status
// Optional: define PE_SCHED_TIMEOUT_EN for the WAIT watchdog.
module pe_scheduler
   import pe_sched_pkg::*;
#(
   parameter int SLOTS = 3,
   parameter int CNT_W = 8
)(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_job_start,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [20:0]           i_addr,
   input  logic [15:0]           i_w,
   input  logic [15:0]           i_ia,
   input  logic                  i_last,
   output logic                  o_pe_start,
   output logic [SLOTS*21-1:0]   o_pe_addr,
   output logic [SLOTS*16-1:0]   o_pe_w,
   output logic [SLOTS*16-1:0]   o_pe_ia,
   input  logic                  i_pe_finish,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic [CNT_W-1:0]      o_triple_cnt
);

   pe_state_e        r_state;
   pe_state_e        w_state_nxt;
   logic             r_last;
   logic [CNT_W-1:0] r_cnt;
   logic             w_accept;
   logic             w_close;
   logic             w_clear;
   logic             w_job_go;
   logic             w_timeout;

   assign o_ready    = (r_state == ST_COLLECT);
   assign o_pe_start = (r_state == ST_ISSUE);
   assign o_done     = (r_state == ST_DONE);
   assign o_busy     = (r_state != ST_IDLE);
   assign o_triple_cnt = r_cnt;

   assign w_accept = i_valid & o_ready;
   assign w_job_go = (r_state == ST_IDLE) & i_job_start;
   assign w_clear  = (w_state_nxt == ST_COLLECT) &
                     (r_state != ST_COLLECT);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:    if (i_job_start) w_state_nxt = ST_COLLECT;
         ST_COLLECT: if (w_close) w_state_nxt = ST_ISSUE;
         ST_ISSUE:   w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (i_pe_finish)
               w_state_nxt = r_last ? ST_DONE : ST_COLLECT;
            else if (w_timeout)
               w_state_nxt = ST_DONE;
         end
         ST_DONE:    w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_job_go)
            r_last <= 1'b0;
         else if (w_close)
            r_last <= i_last;
         if (w_job_go)
            r_cnt <= '0;
         else if (o_pe_start && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

`ifdef PE_SCHED_TIMEOUT_EN
   logic [3:0] r_wd;
   logic       r_err;

   // Fires on the TIMEOUT-th WAIT cycle without a finish.
   assign w_timeout = (r_state == ST_WAIT) & ~i_pe_finish &
                      (r_wd == 4'(TIMEOUT-1));
   assign o_error = r_err;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wd  <= 4'd0;
         r_err <= 1'b0;
      end else begin
         if ((r_state == ST_WAIT) && !i_pe_finish)
            r_wd <= r_wd + 4'd1;
         else
            r_wd <= 4'd0;
         if (w_job_go)
            r_err <= 1'b0;
         else if (w_timeout)
            r_err <= 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
   assign o_error   = 1'b0;
`endif

   pe_slot_buf u_slot_buf (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (w_clear),
      .i_accept (w_accept),
      .i_last   (i_last),
      .i_addr   (i_addr),
      .i_w      (i_w),
      .i_ia     (i_ia),
      .o_close  (w_close),
      .o_addr   (o_pe_addr),
      .o_w      (o_pe_w),
      .o_ia     (o_pe_ia)
   );

endmodule

// File: tb/tb_pe_scheduler.sv
// tb_pe_scheduler: job table plus directed corner sequences for
// pe_scheduler; issued triples are checked against a scoreboard queue.
module tb_pe_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        job_start = 1'b0;
   logic        valid = 1'b0;
   logic        ready;
   logic [20:0] addr = '0;
   logic [15:0] w = '0;
   logic [15:0] ia = '0;
   logic        last = 1'b0;
   logic        pe_start;
   logic [62:0] pe_addr;
   logic [47:0] pe_w;
   logic [47:0] pe_ia;
   logic        pe_finish = 1'b0;
   logic        busy;
   logic        done;
   logic        error;
   logic [7:0]  tcnt;

   pe_scheduler #(.SLOTS(3), .CNT_W(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_job_start(job_start),
      .i_valid(valid), .o_ready(ready), .i_addr(addr),
      .i_w(w), .i_ia(ia), .i_last(last),
      .o_pe_start(pe_start), .o_pe_addr(pe_addr),
      .o_pe_w(pe_w), .o_pe_ia(pe_ia), .i_pe_finish(pe_finish),
      .o_busy(busy), .o_done(done), .o_error(error),
      .o_triple_cnt(tcnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [62:0] a;
      logic [47:0] w;
      logic [47:0] ia;
   } issue_t;

   typedef struct {
      int nbeats;
      int gap;
      int exp_cnt;
   } job_vec_t;

   issue_t sb[$];
   issue_t m_cur;
   issue_t last_iss;
   bit     have_iss = 0;
   int     m_cnt = 0;
   int     n_cmp = 0;
   int     n_err = 0;
   int     n_start = 0;
   int     n_done = 0;
   bit     auto_fin = 1;

   task automatic check(input string nm,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic model_accept(input logic [20:0] a,
                               input logic [15:0] bw,
                               input logic [15:0] bia,
                               input bit l);
      m_cur.a[m_cnt*21 +: 21]  = a;
      m_cur.w[m_cnt*16 +: 16]  = bw;
      m_cur.ia[m_cnt*16 +: 16] = bia;
      if (l || m_cnt == 2) begin
         for (int k = m_cnt + 1; k < 3; k++) begin
            m_cur.a[k*21 +: 21]  = a;
            m_cur.w[k*16 +: 16]  = 16'h0;
            m_cur.ia[k*16 +: 16] = 16'h0;
         end
         sb.push_back(m_cur);
         m_cnt = 0;
      end else begin
         m_cnt++;
      end
   endtask

   // Called at a negedge; returns at the negedge after the transfer.
   task automatic send_beat(input logic [20:0] a,
                            input logic [15:0] bw,
                            input logic [15:0] bia,
                            input bit l);
      int t;
      addr = a; w = bw; ia = bia; last = l; valid = 1'b1;
      t = 0;
      while (!ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL ready_timeout: got 0 expected 1 at %0t", $time);
         valid = 1'b0;
         return;
      end
      model_accept(a, bw, bia, l);
      @(negedge clk);
      valid = 1'b0;
      last = 1'b0;
   endtask

   task automatic rand_beat(input bit l);
      send_beat(21'($urandom), 16'($urandom), 16'($urandom), l);
   endtask

   task automatic start_job();
      job_start = 1'b1;
      @(negedge clk);
      job_start = 1'b0;
      check("cnt_cleared", 64'(tcnt), 64'd0);
      check("busy_in_job", 64'(busy), 64'd1);
   endtask

   task automatic wait_done(input int exp_cnt, input int d0);
      int t;
      t = 0;
      while (!done && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("done_seen", 64'(done), 64'd1);
      check("triple_cnt", 64'(tcnt), 64'(exp_cnt));
      check("busy_in_done", 64'(busy), 64'd1);
      @(negedge clk);
      check("idle_after_done", 64'(busy), 64'd0);
      check("done_one_cycle", 64'(done), 64'd0);
      check("done_pulses", 64'(n_done - d0), 64'd1);
   endtask

   // Monitor: pops the scoreboard on each issue, checks hold in WAIT.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (done) n_done++;
         if (pe_start) begin
            n_start++;
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_issue: got start expected none at %0t",
                        $time);
            end else begin
               last_iss = sb.pop_front();
               have_iss = 1;
               check("issue_addr", 64'(pe_addr), 64'(last_iss.a));
               check("issue_w", 64'(pe_w), 64'(last_iss.w));
               check("issue_ia", 64'(pe_ia), 64'(last_iss.ia));
            end
         end else if (busy && !ready && !done && have_iss) begin
            check("hold_addr", 64'(pe_addr), 64'(last_iss.a));
            check("hold_w", 64'(pe_w), 64'(last_iss.w));
         end
      end
   end

   // Reducer model: finishes a couple of cycles after each start.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (pe_start && auto_fin) begin
            @(negedge clk);
            @(negedge clk);
            pe_finish = 1'b1;
            @(negedge clk);
            pe_finish = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   job_vec_t jobs[6];
   logic [20:0] a31;

   initial begin
      int d0;
      int s0;
      jobs[0] = '{nbeats: 6,   gap: 0, exp_cnt: 2};
      jobs[1] = '{nbeats: 4,   gap: 0, exp_cnt: 2};
      jobs[2] = '{nbeats: 3,   gap: 1, exp_cnt: 1};
      jobs[3] = '{nbeats: 1,   gap: 0, exp_cnt: 1};
      jobs[4] = '{nbeats: 8,   gap: 2, exp_cnt: 3};
      jobs[5] = '{nbeats: 770, gap: 0, exp_cnt: 255};

      repeat (2) @(negedge clk);
      check("rst_ready", 64'(ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_cnt", 64'(tcnt), 64'd0);
      check("rst_addr", 64'(pe_addr), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int j = 0; j < 6; j++) begin
         d0 = n_done;
         s0 = n_start;
         start_job();
         for (int b = 0; b < jobs[j].nbeats; b++) begin
            if (b > 0) repeat (jobs[j].gap) @(negedge clk);
            rand_beat(b == jobs[j].nbeats - 1);
         end
         wait_done(jobs[j].exp_cnt, d0);
         check("issue_count", 64'(n_start - s0),
               64'((jobs[j].nbeats + 2) / 3));
         check("error_clear", 64'(error), 64'd0);
      end

      // Early close: padding copies the closing beat's address.
      a31 = {7'h0A, 7'h05, 7'h03};
      d0 = n_done;
      start_job();
      repeat (3) rand_beat(1'b0);
      send_beat(a31, 16'd7, 16'd9, 1'b1);
      check("pad_w", 64'(pe_w), 64'({32'h0, 16'd7}));
      check("pad_ia", 64'(pe_ia), 64'({32'h0, 16'd9}));
      check("pad_addr", 64'(pe_addr), 64'({a31, a31, a31}));
      wait_done(2, d0);

      // Valid gap stalls collection without issuing.
      d0 = n_done;
      start_job();
      repeat (2) rand_beat(1'b0);
      for (int i = 0; i < 5; i++) begin
         check("gap_ready", 64'(ready), 64'd1);
         check("gap_no_start", 64'(pe_start), 64'd0);
         @(negedge clk);
      end
      rand_beat(1'b1);
      check("start_after_close", 64'(pe_start), 64'd1);
      wait_done(1, d0);

      // Job start during WAIT is ignored.
      auto_fin = 0;
      d0 = n_done;
      start_job();
      repeat (3) rand_beat(1'b0);
      @(negedge clk);
      job_start = 1'b1;
      @(negedge clk);
      job_start = 1'b0;
      check("ign_start_busy", 64'(busy), 64'd1);
      check("ign_start_ready", 64'(ready), 64'd0);
      check("ign_start_cnt", 64'(tcnt), 64'd1);
      pe_finish = 1'b1;
      @(negedge clk);
      pe_finish = 1'b0;
      check("wait_to_collect", 64'(ready), 64'd1);
      auto_fin = 1;
      rand_beat(1'b1);
      wait_done(2, d0);

      // Asynchronous reset in the middle of WAIT.
      auto_fin = 0;
      start_job();
      repeat (3) rand_beat(1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_ready", 64'(ready), 64'd0);
      check("arst_start", 64'(pe_start), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      check("arst_error", 64'(error), 64'd0);
      check("arst_cnt", 64'(tcnt), 64'd0);
      check("arst_addr", 64'(pe_addr), 64'd0);
      check("arst_w", 64'(pe_w), 64'd0);
      check("arst_ia", 64'(pe_ia), 64'd0);
      have_iss = 0;
      m_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      pe_finish = 1'b1;
      @(negedge clk);
      pe_finish = 1'b0;
      repeat (3) @(negedge clk);
      check("late_fin_busy", 64'(busy), 64'd0);
      check("late_fin_ready", 64'(ready), 64'd0);
      check("late_fin_done", 64'(done), 64'd0);

`ifdef PE_SCHED_TIMEOUT_EN
      begin
         int k;
         start_job();
         rand_beat(1'b1);
         @(negedge clk);
         k = 0;
         while (!done && k < 40) begin
            @(negedge clk);
            k++;
         end
         check("wd_cycles", 64'(k), 64'd15);
         check("wd_error", 64'(error), 64'd1);
         @(negedge clk);
         check("wd_idle", 64'(busy), 64'd0);
         check("wd_sticky", 64'(error), 64'd1);
         job_start = 1'b1;
         @(negedge clk);
         job_start = 1'b0;
         check("wd_err_cleared", 64'(error), 64'd0);
         auto_fin = 1;
         rand_beat(1'b1);
         wait_done(1, n_done);
      end
`endif

      auto_fin = 1;
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pe_scheduler.md
PE_SCHEDULER -- requirements
Module: pe_scheduler

Interface
REQ-001 SHALL have parameter SLOTS, default 3, meaning operand lanes per reducer issue (fixed at 3 in this revision).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the issued-triple counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low: i_clk input 1, rising-edge clock; i_rst_n input 1, async active-low reset.
REQ-004 i_job_start  input  1  pulse that starts a job; honoured only in IDLE.
REQ-005 i_valid  input  1  stream beat valid.
REQ-006 o_ready  output  1  scheduler accepts a beat; transfer occurs when i_valid&o_ready.
REQ-007 i_addr  input  21  packed 3x7-bit coordinate of the beat.
REQ-008 i_w, i_ia  input  16 each  weight and input activation of the beat.
REQ-009 i_last  input  1  marks the final beat of the job; qualified by i_valid.
REQ-010 o_pe_start  output  1  one-cycle start pulse to the reducer.
REQ-011 o_pe_addr  output  3x21; o_pe_w, o_pe_ia  output  3x16 each; registered slot operands to the reducer.
REQ-012 i_pe_finish  input  1  reducer completion pulse.
REQ-013 o_busy  output  1; o_done  output  1 (one-cycle pulse); o_error  output  1 (sticky until next i_job_start); o_triple_cnt  output  CNT_W.

Function
REQ-014 States: IDLE, COLLECT, ISSUE, WAIT, DONE; IDLE->COLLECT on i_job_start; COLLECT->ISSUE when third beat accepted or a beat with i_last accepted; ISSUE->WAIT unconditionally; WAIT->DONE on i_pe_finish if job's last beat was issued, else WAIT->COLLECT; DONE->IDLE unconditionally.
REQ-015 o_ready SHALL be 1 only in COLLECT; no beat is accepted in any other state.
REQ-016 Accepted beats fill slots 0,1,2 in arrival order; slot count clears on entry to COLLECT.
REQ-017 On early close by i_last, unfilled slots SHALL be padded with w=0, ia=0, addr equal to the last filled slot's addr, so the reducer merges them with zero contribution.
REQ-018 o_pe_start SHALL be 1 exactly during ISSUE, i.e. the cycle after the closing beat is accepted.
REQ-019 o_pe_addr/w/ia SHALL hold stable from ISSUE until leaving WAIT.
REQ-020 o_triple_cnt SHALL increment by 1 in each ISSUE cycle, clear on i_job_start, saturate at 2^CNT_W-1.
REQ-021 o_done SHALL be 1 only in DONE; o_busy SHALL be 1 in every state except IDLE.
REQ-022 i_job_start outside IDLE SHALL be ignored; i_pe_finish outside WAIT SHALL be ignored.
REQ-023 Gaps in i_valid during COLLECT SHALL stall without timeout or issue.

Reset
REQ-024 Async assertion of i_rst_n=0 SHALL force IDLE, all slot registers 0, o_ready=0, o_pe_start=0, o_busy=0, o_done=0, o_error=0, o_triple_cnt=0, at any state including mid-WAIT.
REQ-025 Reset release SHALL take effect on the first following rising i_clk edge; no operation resumes.

Configuration
REQ-026 Macro PE_SCHED_TIMEOUT_EN defined: 4-bit watchdog counts WAIT cycles; on reaching 15 without i_pe_finish, SHALL set o_error=1 and go to DONE.
REQ-027 Macro undefined: no watchdog logic, WAIT persists until i_pe_finish, o_error tied 0.

Structure
REQ-028 Package pe_sched_pkg SHALL hold the state enum, SLOTS=3, ADDR_W=7, COORD_N=3, DATA_W=16, TIMEOUT=15.
REQ-029 One sub-module pe_slot_buf SHALL hold slot fill, padding and operand registers; FSM, counter and watchdog stay in pe_scheduler.

Verification
REQ-030 Job of 6 beats, i_last on beat 6, reducer finish 3 cycles after start -> two o_pe_start pulses, o_triple_cnt=2, one o_done pulse after second finish.
REQ-031 Job of 4 beats, beat 4 addr=0x0A_05_03 w=7 ia=9 -> second issue slot0=beat4, slots 1,2 w=0 ia=0 addr=0x0A_05_03.
REQ-032 i_valid low 5 cycles after beat 2 -> o_ready stays 1, no o_pe_start until beat 3 accepted, then start next cycle.
REQ-033 PE_SCHED_TIMEOUT_EN defined, i_pe_finish tied 0 -> o_error=1 and o_done pulse 15 cycles after entering WAIT; then IDLE.
REQ-034 i_rst_n pulsed low during WAIT -> all outputs at reset values immediately; late i_pe_finish ignored.
REQ-035 i_job_start pulsed during WAIT -> no state change, o_triple_cnt unchanged.
